// File: rtl/lfsr_power_seq_ctrl.sv
// Power-state sequencer for the switchable LFSR domain (Domain-2).
// Sequences save -> isolate -> switch off and switch on -> restore -> de-isolate,
// keeping isolation asserted over the whole unpowered window.
// Ports:
//   clk          sequencer clock
//   rst          asynchronous active-low reset
//   pd_req       power-down request, sampled only in ST_ON
//   pu_req       power-up request, sampled only in ST_OFF
//   pwr_good     Domain-2 supply status (1 = powered)
//   save_lfsr    retention save strobe
//   restore_lfsr retention restore strobe
//   iso2         Domain-2 isolation enable
//   lfsr_sw_ctr  power switch control (0 = ON, 1 = OFF)
//   busy         high outside ST_ON / ST_OFF
//   dom_off      high only in ST_OFF
//   pg_err       sticky pwr_good timeout flag
//   state        current state encoding (debug)
module lfsr_power_seq_ctrl #(
  parameter int unsigned SAVE_CYC    = 2,
  parameter int unsigned ISO_SETUP   = 4,
  parameter int unsigned RESTORE_CYC = 2,
  parameter int unsigned ISO_HOLD    = 2,
  parameter int unsigned PG_TIMEOUT  = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pd_req,
  input  logic       pu_req,
  input  logic       pwr_good,
  output logic       save_lfsr,
  output logic       restore_lfsr,
  output logic       iso2,
  output logic       lfsr_sw_ctr,
  output logic       busy,
  output logic       dom_off,
  output logic       pg_err,
  output logic [2:0] state
);

  localparam int unsigned ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_ON      = 3'd0,
    ST_SAVE    = 3'd1,
    ST_ISO     = 3'd2,
    ST_SWOFF   = 3'd3,
    ST_OFF     = 3'd4,
    ST_SWON    = 3'd5,
    ST_RESTORE = 3'd6,
    ST_UNISO   = 3'd7
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_timer;
  logic [CNT_W-1:0]   w_timer_nxt;
  logic               r_pg_err;
  logic               w_pg_err_nxt;
  logic               w_timer_zero;

  logic               w_save_nxt;
  logic               w_restore_nxt;
  logic               w_iso_nxt;
  logic               w_sw_nxt;
  logic               w_busy_nxt;
  logic               w_dom_off_nxt;

  assign w_timer_zero = (r_timer == '0);

  // State, timer and sticky error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_ON;
      r_timer  <= '0;
      r_pg_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_pg_err <= w_pg_err_nxt;
    end
  end

  // Next-state logic; the timer is reloaded whenever a new state is entered
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_pg_err_nxt = r_pg_err;

    case (r_state)
      ST_ON: begin
        if (pd_req) w_state_nxt = ST_SAVE;
      end
      ST_SAVE: begin
        if (w_timer_zero) w_state_nxt = ST_ISO;
        else              w_timer_nxt = r_timer - CNT_W'(1);
      end
      ST_ISO: begin
        if (w_timer_zero) w_state_nxt = ST_SWOFF;
        else              w_timer_nxt = r_timer - CNT_W'(1);
      end
      ST_SWOFF: begin
        if (!pwr_good) begin
          w_state_nxt = ST_OFF;
        end else if (w_timer_zero) begin
          w_state_nxt  = ST_OFF;
          w_pg_err_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end
      end
      ST_OFF: begin
        if (pu_req) w_state_nxt = ST_SWON;
      end
      ST_SWON: begin
        // A supply that never comes up falls back to OFF with the switch opened
        if (pwr_good) begin
          w_state_nxt = ST_RESTORE;
        end else if (w_timer_zero) begin
          w_state_nxt  = ST_OFF;
          w_pg_err_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end
      end
      ST_RESTORE: begin
        if (w_timer_zero) w_state_nxt = ST_UNISO;
        else              w_timer_nxt = r_timer - CNT_W'(1);
      end
      ST_UNISO: begin
        if (w_timer_zero) w_state_nxt = ST_ON;
        else              w_timer_nxt = r_timer - CNT_W'(1);
      end
      default: begin
        w_state_nxt = ST_ON;
      end
    endcase

    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        ST_SAVE:    w_timer_nxt = CNT_W'(SAVE_CYC - 1);
        ST_ISO:     w_timer_nxt = CNT_W'(ISO_SETUP - 1);
        ST_SWOFF:   w_timer_nxt = CNT_W'(PG_TIMEOUT - 1);
        ST_SWON:    w_timer_nxt = CNT_W'(PG_TIMEOUT - 1);
        ST_RESTORE: w_timer_nxt = CNT_W'(RESTORE_CYC - 1);
        ST_UNISO:   w_timer_nxt = CNT_W'(ISO_HOLD - 1);
        default:    w_timer_nxt = '0;
      endcase
    end
  end

  // Output decode from the next state so registered outputs track the state register
  always_comb begin
    w_save_nxt    = 1'b0;
    w_restore_nxt = 1'b0;
    w_iso_nxt     = 1'b1;
    w_sw_nxt      = 1'b0;
    w_busy_nxt    = 1'b1;
    w_dom_off_nxt = 1'b0;

    case (w_state_nxt)
      ST_ON: begin
        w_iso_nxt  = 1'b0;
        w_busy_nxt = 1'b0;
      end
      ST_SAVE: begin
        w_iso_nxt  = 1'b0;
        w_save_nxt = 1'b1;
      end
      ST_SWOFF: begin
        w_sw_nxt = 1'b1;
      end
      ST_OFF: begin
        w_sw_nxt      = 1'b1;
        w_busy_nxt    = 1'b0;
        w_dom_off_nxt = 1'b1;
      end
      ST_RESTORE: begin
        w_restore_nxt = 1'b1;
      end
      default: begin
        w_iso_nxt = 1'b1;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      save_lfsr    <= 1'b0;
      restore_lfsr <= 1'b0;
      iso2         <= 1'b0;
      lfsr_sw_ctr  <= 1'b0;
      busy         <= 1'b0;
      dom_off      <= 1'b0;
    end else begin
      save_lfsr    <= w_save_nxt;
      restore_lfsr <= w_restore_nxt;
      iso2         <= w_iso_nxt;
      lfsr_sw_ctr  <= w_sw_nxt;
      busy         <= w_busy_nxt;
      dom_off      <= w_dom_off_nxt;
    end
  end

  assign pg_err = r_pg_err;
  assign state  = r_state;

endmodule

// File: tb/tb_lfsr_power_seq_ctrl.sv
// Directed testbench for lfsr_power_seq_ctrl. The supply model follows the
// switch through a two-flop delay (pwr_good settles three cycles after the
// switch output changes, as seen by the sequencer) or can be forced high/low.
module tb_lfsr_power_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       pd_req;
  logic       pu_req;
  logic       pwr_good;
  logic       save_lfsr;
  logic       restore_lfsr;
  logic       iso2;
  logic       lfsr_sw_ctr;
  logic       busy;
  logic       dom_off;
  logic       pg_err;
  logic [2:0] state;

  int total;
  int bad;

  int         pg_mode;      // 0 follow switch, 1 force high, 2 force low
  logic [1:0] pg_sh = 2'b11;
  logic [9:0] obs_v;

  lfsr_power_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pd_req       (pd_req),
    .pu_req       (pu_req),
    .pwr_good     (pwr_good),
    .save_lfsr    (save_lfsr),
    .restore_lfsr (restore_lfsr),
    .iso2         (iso2),
    .lfsr_sw_ctr  (lfsr_sw_ctr),
    .busy         (busy),
    .dom_off      (dom_off),
    .pg_err       (pg_err),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) pg_sh <= {pg_sh[0], ~lfsr_sw_ctr};

  assign pwr_good = (pg_mode == 0) ? pg_sh[1] : (pg_mode == 1);
  assign obs_v = {state, save_lfsr, restore_lfsr, iso2, lfsr_sw_ctr, busy, dom_off, pg_err};

  // Expected output vector for a state, straight from the state table
  function automatic logic [9:0] exp_v(input int st, input logic pe);
    logic s, r, i, w, b, d;
    s = (st == 1);
    r = (st == 6);
    i = (st >= 2);
    w = (st == 3) || (st == 4);
    b = !((st == 0) || (st == 4));
    d = (st == 4);
    return {3'(st), s, r, i, w, b, d, pe};
  endfunction

  task automatic test_reset();
    logic [9:0] e;
    rst = 1'b0; pd_req = 1'b0; pu_req = 1'b0; pg_mode = 0;
    repeat (3) @(negedge clk);
    e = exp_v(0, 1'b0);
    total++;
    if (obs_v !== e) begin
      bad++;
      $display("FAIL reset got=%h want=%h", obs_v, e);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (obs_v !== e) begin
      bad++;
      $display("FAIL reset_idle got=%h want=%h", obs_v, e);
    end
  endtask

  // pd pulse from ON with supply following switch: OFF reached three cycles after switch-off
  task automatic test_power_down();
    int dn [10] = '{1, 1, 2, 2, 2, 2, 3, 3, 3, 4};
    logic [9:0] e;
    pd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pd_req = 1'b0;
      e = exp_v(dn[i], 1'b0);
      total++;
      if (obs_v !== e) begin
        bad++;
        $display("FAIL power_down cyc%0d got=%h want=%h", i, obs_v, e);
      end
    end
  endtask

  task automatic test_power_up();
    int up [8] = '{5, 5, 5, 6, 6, 7, 7, 0};
    logic [9:0] e;
    pu_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pu_req = 1'b0;
      e = exp_v(up[i], 1'b0);
      total++;
      if (obs_v !== e) begin
        bad++;
        $display("FAIL power_up cyc%0d got=%h want=%h", i, obs_v, e);
      end
    end
  endtask

  task automatic test_ignore_requests();
    logic [9:0] e;
    e = exp_v(0, 1'b0);
    pu_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (obs_v !== e) begin
        bad++;
        $display("FAIL ignore_pu_on cyc%0d got=%h want=%h", i, obs_v, e);
      end
    end
    pu_req = 1'b0;
    pd_req = 1'b1;
    @(negedge clk);
    repeat (9) @(negedge clk);
    e = exp_v(4, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (obs_v !== e) begin
        bad++;
        $display("FAIL ignore_pd_off cyc%0d got=%h want=%h", i, obs_v, e);
      end
    end
    pd_req = 1'b0;
    pu_req = 1'b1;
    @(negedge clk);
    pu_req = 1'b0;
    repeat (7) @(negedge clk);
    e = exp_v(0, 1'b0);
    total++;
    if (obs_v !== e) begin
      bad++;
      $display("FAIL ignore_return got=%h want=%h", obs_v, e);
    end
  endtask

  // Supply stuck high on power-down, then stuck low on power-up
  task automatic test_pg_timeout();
    logic [9:0] e;
    int dn [6] = '{1, 1, 2, 2, 2, 2};
    pg_mode = 1;
    pd_req  = 1'b1;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      pd_req = 1'b0;
      if (i < 6)       e = exp_v(dn[i], 1'b0);
      else if (i < 22) e = exp_v(3, 1'b0);
      else             e = exp_v(4, 1'b1);
      total++;
      if (obs_v !== e) begin
        bad++;
        $display("FAIL pg_timeout_down cyc%0d got=%h want=%h", i, obs_v, e);
      end
    end
    pg_mode = 2;
    pu_req  = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      pu_req = 1'b0;
      e = (i < 16) ? exp_v(5, 1'b1) : exp_v(4, 1'b1);
      total++;
      if (obs_v !== e) begin
        bad++;
        $display("FAIL pg_timeout_up cyc%0d got=%h want=%h", i, obs_v, e);
      end
    end
  endtask

  // Asynchronous reset mid-sequence, sampled between clock edges
  task automatic test_reset_mid();
    logic [9:0] e;
    e = exp_v(0, 1'b0);
    pg_mode = 0;
    #2 rst = 1'b0;
    #1;
    total++;
    if (obs_v !== e) begin
      bad++;
      $display("FAIL reset_in_off got=%h want=%h", obs_v, e);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    pd_req = 1'b1;
    repeat (3) @(negedge clk);
    pd_req = 1'b0;
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL reach_iso got=%0d want=2", state);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (obs_v !== e) begin
      bad++;
      $display("FAIL reset_in_iso got=%h want=%h", obs_v, e);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    pd_req = 1'b1;
    @(negedge clk);
    pd_req = 1'b0;
    repeat (9) @(negedge clk);
    total++;
    if (obs_v !== exp_v(4, 1'b0)) begin
      bad++;
      $display("FAIL reach_off got=%h want=%h", obs_v, exp_v(4, 1'b0));
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (obs_v !== e || pwr_good !== 1'b0) begin
      bad++;
      $display("FAIL reset_off_pg_low got=%h want=%h pg=%b", obs_v, e, pwr_good);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Both requests held: sequence must cycle continuously with invariants intact
  task automatic test_back_to_back();
    int n_off;
    int n_on;
    logic prev_off;
    n_off = 0; n_on = 0; prev_off = 1'b0;
    pd_req = 1'b1;
    pu_req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      total++;
      if (save_lfsr && restore_lfsr) begin
        bad++;
        $display("FAIL b2b_overlap cyc%0d got=1 want=0", i);
      end
      total++;
      if ((lfsr_sw_ctr || (!pwr_good && state != 3'd0)) && !iso2) begin
        bad++;
        $display("FAIL b2b_iso cyc%0d got=%b want=1", i, iso2);
      end
      if (state == 3'd4) begin
        n_off++;
        prev_off = 1'b1;
      end
      if (state == 3'd0 && prev_off) begin
        n_on++;
        prev_off = 1'b0;
      end
    end
    pd_req = 1'b0;
    pu_req = 1'b0;
    total++;
    if (n_off < 3 || n_on < 2) begin
      bad++;
      $display("FAIL b2b_cycling got=off%0d/on%0d want>=3/2", n_off, n_on);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_power_down();
    test_power_up();
    test_ignore_requests();
    test_pg_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
